// File: rtl/dpram_port_arbiter_if.sv
// Bus bundle between the four requesters, the dual-port RAM and dpram_port_arbiter.
// slave = arbiter view, master = requester/RAM side view.
interface dpram_arb_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic [3:0]              req_valid;
  logic [3:0]              req_we;
  logic [4*ADDR_WIDTH-1:0] req_addr;
  logic [4*DATA_WIDTH-1:0] req_data;
  logic [3:0]              req_ready;

  logic                    we1;
  logic [ADDR_WIDTH-1:0]   addr1;
  logic [DATA_WIDTH-1:0]   data1;
  logic                    we2;
  logic [ADDR_WIDTH-1:0]   addr2;
  logic [DATA_WIDTH-1:0]   data2;
  logic [DATA_WIDTH-1:0]   out1;
  logic [DATA_WIDTH-1:0]   out2;

  logic [3:0]              rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp1_data;
  logic [DATA_WIDTH-1:0]   rsp2_data;
  logic [3:0]              rsp_port;

  modport slave (
    input  req_valid, req_we, req_addr, req_data, out1, out2,
    output req_ready, we1, addr1, data1, we2, addr2, data2,
           rsp_valid, rsp1_data, rsp2_data, rsp_port
  );

  modport master (
    output req_valid, req_we, req_addr, req_data, out1, out2,
    input  req_ready, we1, addr1, data1, we2, addr2, data2,
           rsp_valid, rsp1_data, rsp2_data, rsp_port
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter mapping 4 requesters onto the two ports of a dual-port RAM.
// Optional DPRAM_ARB_STATS_EN adds saturating conflict_count / grant_count outputs.
module dpram_port_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  dpram_arb_if.slave        bus
`ifdef DPRAM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_count,
  output logic [15:0]       grant_count
`endif
);

  logic [1:0]            rr_ptr;
  logic [3:0]            rsp_valid_q;
  logic [3:0]            rsp_port_q;

  logic [1:0]            first;
  logic [1:0]            second;
  logic                  found1;
  logic                  found2;
  logic [ADDR_WIDTH-1:0] addr_first;
  logic [ADDR_WIDTH-1:0] addr_second;
  logic                  conflict;
  logic                  gnt1;
  logic                  gnt2;
  logic [3:0]            oh1;
  logic [3:0]            oh2;
  logic [3:0]            rd1_oh;
  logic [3:0]            rd2_oh;
  logic [1:0]            last;

  // Scan from rr_ptr upward; the first two valid requesters become port candidates.
  always_comb begin
    logic [1:0] idx;
    idx    = '0;
    first  = '0;
    second = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (bus.req_valid[idx]) begin
        if (!found1) begin
          first  = idx;
          found1 = 1'b1;
        end else if (!found2) begin
          second = idx;
          found2 = 1'b1;
        end
      end
    end
  end

  assign addr_first  = bus.req_addr[first*ADDR_WIDTH +: ADDR_WIDTH];
  assign addr_second = bus.req_addr[second*ADDR_WIDTH +: ADDR_WIDTH];

  // Same-address pairs involving a write would race inside the RAM; hold the second.
  assign conflict = found2 && (addr_first == addr_second) &&
                    (bus.req_we[first] || bus.req_we[second]);

  assign gnt1 = found1 && !reset;
  assign gnt2 = found2 && !conflict && !reset;

  assign oh1 = gnt1 ? (4'b0001 << first)  : 4'b0000;
  assign oh2 = gnt2 ? (4'b0001 << second) : 4'b0000;

  assign rd1_oh = bus.req_we[first]  ? 4'b0000 : oh1;
  assign rd2_oh = bus.req_we[second] ? 4'b0000 : oh2;

  assign last = gnt2 ? second : first;

  always_comb begin
    bus.req_ready = oh1 | oh2;
    bus.we1   = 1'b0;
    bus.addr1 = '0;
    bus.data1 = '0;
    bus.we2   = 1'b0;
    bus.addr2 = '0;
    bus.data2 = '0;
    if (gnt1) begin
      bus.we1   = bus.req_we[first];
      bus.addr1 = addr_first;
      bus.data1 = bus.req_data[first*DATA_WIDTH +: DATA_WIDTH];
    end
    if (gnt2) begin
      bus.we2   = bus.req_we[second];
      bus.addr2 = addr_second;
      bus.data2 = bus.req_data[second*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Reads granted while reset is high never reach these flops, so nothing leaks out after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= 2'd0;
      rsp_valid_q <= 4'b0000;
      rsp_port_q  <= 4'b0000;
    end else begin
      if (gnt1) rr_ptr <= last + 2'd1;
      rsp_valid_q <= rd1_oh | rd2_oh;
      rsp_port_q  <= rd2_oh;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_port  = rsp_port_q;
  assign bus.rsp1_data = bus.out1;
  assign bus.rsp2_data = bus.out2;

`ifdef DPRAM_ARB_STATS_EN
  logic [16:0] grant_sum;
  assign grant_sum = {1'b0, grant_count} + {16'd0, gnt1} + {16'd0, gnt2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_count <= 16'd0;
      grant_count    <= 16'd0;
    end else begin
      if (conflict && conflict_count != 16'hFFFF) conflict_count <= conflict_count + 16'd1;
      grant_count <= grant_sum[16] ? 16'hFFFF : grant_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural dual-port RAM on the port side.
// Build with DPRAM_ARB_STATS_EN defined to also exercise the statistics counters.
module tb_dpram_port_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dpram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

`ifdef DPRAM_ARB_STATS_EN
  logic [15:0] conflict_count;
  logic [15:0] grant_count;
`endif

  dpram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DPRAM_ARB_STATS_EN
    ,
    .conflict_count (conflict_count),
    .grant_count    (grant_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] init_val(logic [6:0] a);
    return 32'hA500_0000 | {25'd0, a};
  endfunction

  function automatic logic [31:0] dpat(int i, logic [6:0] a);
    return 32'hD000_0000 | (32'(i) << 16) | {25'd0, a};
  endfunction

  // Behavioural RAM: unwritten words read back as init_val(addr).
  logic [31:0]  ram [128];
  logic [127:0] wr_mask;
  always @(posedge clk) begin
    if (reset) wr_mask <= '0;
    else begin
      if (bus.we1) begin ram[bus.addr1] <= bus.data1; wr_mask[bus.addr1] <= 1'b1; end
      if (bus.we2) begin ram[bus.addr2] <= bus.data2; wr_mask[bus.addr2] <= 1'b1; end
    end
    bus.out1 <= wr_mask[bus.addr1] ? ram[bus.addr1] : init_val(bus.addr1);
    bus.out2 <= wr_mask[bus.addr2] ? ram[bus.addr2] : init_val(bus.addr2);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(logic [3:0] v, logic [3:0] w,
                        logic [6:0] a0, logic [6:0] a1, logic [6:0] a2, logic [6:0] a3);
    bus.req_valid = v;
    bus.req_we    = w;
    bus.req_addr  = {a3, a2, a1, a0};
    bus.req_data  = {dpat(3, a3), dpat(2, a2), dpat(1, a1), dpat(0, a0)};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(4'b0000, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // g1/p1: port-1 winner, g2/p2: port-2 winner, hand-derived from the round-robin order.
  typedef struct {
    logic [3:0] valid;
    logic [3:0] we;
    logic [6:0] a0, a1, a2, a3;
    logic       g1;
    logic [1:0] p1;
    logic       g2;
    logic [1:0] p2;
  } vec_t;

  vec_t tbl [14];

  logic [6:0]  ad [4];
  logic [3:0]  exp_ready, rv, rp;
  logic        pg1, pg2, pr1, pr2;
  logic [1:0]  pp1, pp2;
  logic [6:0]  pa1, pa2;
  logic [2:0]  rnd;
  int          run, max_run, bad_ready;

  initial begin
    tbl[0]  = '{4'b1111, 4'b0000, 7'd1,    7'd2,    7'd3,    7'd4,    1'b1, 2'd0, 1'b1, 2'd1};
    tbl[1]  = '{4'b1111, 4'b0000, 7'd1,    7'd2,    7'd3,    7'd4,    1'b1, 2'd2, 1'b1, 2'd3};
    tbl[2]  = '{4'b0000, 4'b0000, 7'd0,    7'd0,    7'd0,    7'd0,    1'b0, 2'd0, 1'b0, 2'd0};
    tbl[3]  = '{4'b0100, 4'b0000, 7'd0,    7'd0,    7'd9,    7'd0,    1'b1, 2'd2, 1'b0, 2'd0};
    tbl[4]  = '{4'b1001, 4'b0000, 7'd10,   7'd0,    7'd0,    7'd11,   1'b1, 2'd3, 1'b1, 2'd0};
    tbl[5]  = '{4'b0011, 4'b0001, 7'h40,   7'h40,   7'd0,    7'd0,    1'b1, 2'd1, 1'b0, 2'd0};
    tbl[6]  = '{4'b0011, 4'b0001, 7'h40,   7'h40,   7'd0,    7'd0,    1'b1, 2'd0, 1'b0, 2'd0};
    tbl[7]  = '{4'b0000, 4'b0000, 7'd0,    7'd0,    7'd0,    7'd0,    1'b0, 2'd0, 1'b0, 2'd0};
    tbl[8]  = '{4'b0110, 4'b0110, 7'd0,    7'h41,   7'h42,   7'd0,    1'b1, 2'd1, 1'b1, 2'd2};
    tbl[9]  = '{4'b1111, 4'b0000, 7'd7,    7'd7,    7'd7,    7'd7,    1'b1, 2'd3, 1'b1, 2'd0};
    tbl[10] = '{4'b0000, 4'b0000, 7'd0,    7'd0,    7'd0,    7'd0,    1'b0, 2'd0, 1'b0, 2'd0};
    tbl[11] = '{4'b1100, 4'b1100, 7'd0,    7'd0,    7'h43,   7'h43,   1'b1, 2'd2, 1'b0, 2'd0};
    tbl[12] = '{4'b1000, 4'b0000, 7'd0,    7'd0,    7'd0,    7'd12,   1'b1, 2'd3, 1'b0, 2'd0};
    tbl[13] = '{4'b0000, 4'b0000, 7'd0,    7'd0,    7'd0,    7'd0,    1'b0, 2'd0, 1'b0, 2'd0};

    // Outputs held at reset values even with every requester asking.
    set_in(4'b1111, 4'b1111, 7'd1, 7'd2, 7'd3, 7'd4);
    #2;
    chk("rst ready",     32'(bus.req_ready), 32'h0);
    chk("rst we1",       32'(bus.we1),       32'h0);
    chk("rst we2",       32'(bus.we2),       32'h0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst rsp_port",  32'(bus.rsp_port),  32'h0);
    do_reset();

    pg1 = 1'b0; pg2 = 1'b0; pr1 = 1'b0; pr2 = 1'b0;
    pp1 = '0; pp2 = '0; pa1 = '0; pa2 = '0;
    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      set_in(tbl[r].valid, tbl[r].we, tbl[r].a0, tbl[r].a1, tbl[r].a2, tbl[r].a3);
      #1;
      ad[0] = tbl[r].a0; ad[1] = tbl[r].a1; ad[2] = tbl[r].a2; ad[3] = tbl[r].a3;

      rv = '0; rp = '0;
      if (pg1 && pr1) rv[pp1] = 1'b1;
      if (pg2 && pr2) begin rv[pp2] = 1'b1; rp[pp2] = 1'b1; end
      chk($sformatf("r%0d rsp_valid", r), 32'(bus.rsp_valid), 32'(rv));
      chk($sformatf("r%0d rsp_port", r), 32'(bus.rsp_port & rv), 32'(rp));
      if (pg1 && pr1) chk($sformatf("r%0d rsp1_data", r), bus.rsp1_data, init_val(pa1));
      if (pg2 && pr2) chk($sformatf("r%0d rsp2_data", r), bus.rsp2_data, init_val(pa2));

      exp_ready = '0;
      if (tbl[r].g1) exp_ready[tbl[r].p1] = 1'b1;
      if (tbl[r].g2) exp_ready[tbl[r].p2] = 1'b1;
      chk($sformatf("r%0d ready", r), 32'(bus.req_ready), 32'(exp_ready));
      chk($sformatf("r%0d we1", r),   32'(bus.we1),
          tbl[r].g1 ? 32'(tbl[r].we[tbl[r].p1]) : 32'h0);
      chk($sformatf("r%0d addr1", r), 32'(bus.addr1), tbl[r].g1 ? 32'(ad[tbl[r].p1]) : 32'h0);
      chk($sformatf("r%0d data1", r), bus.data1,
          tbl[r].g1 ? dpat(int'(tbl[r].p1), ad[tbl[r].p1]) : 32'h0);
      chk($sformatf("r%0d we2", r),   32'(bus.we2),
          tbl[r].g2 ? 32'(tbl[r].we[tbl[r].p2]) : 32'h0);
      chk($sformatf("r%0d addr2", r), 32'(bus.addr2), tbl[r].g2 ? 32'(ad[tbl[r].p2]) : 32'h0);
      chk($sformatf("r%0d data2", r), bus.data2,
          tbl[r].g2 ? dpat(int'(tbl[r].p2), ad[tbl[r].p2]) : 32'h0);

      pg1 = tbl[r].g1; pp1 = tbl[r].p1; pa1 = ad[tbl[r].p1]; pr1 = !tbl[r].we[tbl[r].p1];
      pg2 = tbl[r].g2; pp2 = tbl[r].p2; pa2 = ad[tbl[r].p2]; pr2 = !tbl[r].we[tbl[r].p2];
    end
`ifdef DPRAM_ARB_STATS_EN
    chk("tbl conflict_count", 32'(conflict_count), 32'd3);
    chk("tbl grant_count",    32'(grant_count),    32'd15);
`endif

    // Write/read collision on address 5: write wins, read follows and sees new data.
    do_reset();
    @(negedge clk);
    set_in(4'b0011, 4'b0001, 7'd5, 7'd5, 7'd0, 7'd0);
    #1;
    chk("wr_rd ready c0", 32'(bus.req_ready), 32'b0001);
    chk("wr_rd we1 c0",   32'(bus.we1),       32'h1);
    chk("wr_rd addr1 c0", 32'(bus.addr1),     32'd5);
    chk("wr_rd data1 c0", bus.data1,          dpat(0, 7'd5));
    chk("wr_rd we2 c0",   32'(bus.we2),       32'h0);
    @(negedge clk);
    set_in(4'b0010, 4'b0000, 7'd5, 7'd5, 7'd0, 7'd0);
    #1;
    chk("wr_rd ready c1", 32'(bus.req_ready), 32'b0010);
    chk("wr_rd addr1 c1", 32'(bus.addr1),     32'd5);
    chk("wr_rd rspv c1",  32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    set_in(4'b0000, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    #1;
    chk("wr_rd rspv c2",  32'(bus.rsp_valid), 32'b0010);
    chk("wr_rd port c2",  32'(bus.rsp_port & 4'b0010), 32'h0);
    chk("wr_rd data c2",  bus.rsp1_data, dpat(0, 7'd5));
`ifdef DPRAM_ARB_STATS_EN
    chk("wr_rd conflict_count", 32'(conflict_count), 32'd1);
`endif

    // Two reads of the same address share the cycle (rr_ptr is now 2).
    @(negedge clk);
    set_in(4'b0011, 4'b0000, 7'd7, 7'd7, 7'd0, 7'd0);
    #1;
    chk("rd_rd ready", 32'(bus.req_ready), 32'b0011);
    chk("rd_rd addr1", 32'(bus.addr1), 32'd7);
    chk("rd_rd addr2", 32'(bus.addr2), 32'd7);
    @(negedge clk);
    set_in(4'b0000, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    #1;
    chk("rd_rd rspv",  32'(bus.rsp_valid), 32'b0011);
    chk("rd_rd port",  32'(bus.rsp_port & 4'b0011), 32'b0010);
    chk("rd_rd data1", bus.rsp1_data, init_val(7'd7));
    chk("rd_rd data2", bus.rsp2_data, init_val(7'd7));
`ifdef DPRAM_ARB_STATS_EN
    chk("rd_rd conflict_count", 32'(conflict_count), 32'd1);
`endif

    // Starvation: req3 always valid, others random over a tiny address range to force conflicts.
    run = 0; max_run = 0; bad_ready = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      rnd = 3'($urandom_range(0, 7));
      set_in({1'b1, rnd}, 4'($urandom_range(0, 15)),
             7'($urandom_range(0, 3)), 7'($urandom_range(0, 3)),
             7'($urandom_range(0, 3)), 7'($urandom_range(0, 3)));
      #1;
      if (bus.req_ready[3]) run = 0;
      else begin
        run++;
        if (run > max_run) max_run = run;
      end
      if ($countones(bus.req_ready) > 2 || (bus.req_ready & ~bus.req_valid) != 4'b0000 ||
          bus.req_ready == 4'b0000)
        bad_ready++;
    end
    chk("starve max wait <= 4", 32'(max_run > 4), 32'h0);
    chk("random grant sanity",  32'(bad_ready),   32'h0);

    // Reset mid-burst with reads outstanding.
    @(negedge clk);
    set_in(4'b1111, 4'b0000, 7'd1, 7'd2, 7'd3, 7'd4);
    @(negedge clk);
    #1;
    chk("burst rspv pre-reset", 32'(bus.rsp_valid != 4'b0000), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("mid rst ready", 32'(bus.req_ready), 32'h0);
    chk("mid rst we1",   32'(bus.we1),       32'h0);
    chk("mid rst we2",   32'(bus.we2),       32'h0);
    chk("mid rst rspv",  32'(bus.rsp_valid), 32'h0);
    chk("mid rst port",  32'(bus.rsp_port),  32'h0);
    @(negedge clk);
    set_in(4'b0000, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post rst rspv c1", 32'(bus.rsp_valid), 32'h0);
    set_in(4'b1111, 4'b0000, 7'd1, 7'd2, 7'd3, 7'd4);
    #1;
    chk("post rst rr_ptr=0", 32'(bus.req_ready), 32'b0011);
    @(negedge clk);
    #1;
    chk("post rst rspv c2", 32'(bus.rsp_valid), 32'b0011);

`ifdef DPRAM_ARB_STATS_EN
    // Two grants per cycle for 35005 cycles drives the counter past 0xFFFF.
    do_reset();
    @(negedge clk);
    set_in(4'b1111, 4'b0000, 7'd1, 7'd2, 7'd3, 7'd4);
    repeat (35005) @(negedge clk);
    #1;
    chk("grant_count sat",      32'(grant_count),    32'hFFFF);
    chk("conflict_count quiet", 32'(conflict_count), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
